rf_wb_arbiter: RTL and testbench

Write-back arbiter for the 32-entry register file's single write port. Several producers (ALU result, load return, multi-cycle mul/div) compete for `we3/wa3/wd3`. The block grants one per cycle with round-robin fairness and registers the winning write onto the port. It sits between the execute/memory stages and the register file; its outputs drive the register file write port directly.

---
 rtl/rf_wb_pkg.sv | 10 +
 rtl/rf_wb_arbiter_rr.sv | 31 +++
 rtl/rf_wb_arbiter.sv | 93 +++++++++
 tb/tb_rf_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package rf_wb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int STAT_W     = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [STAT_W-1:0]     stat_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// rr_arbiter: combinational rotating-priority picker; search starts at i_ptr and wraps.
module rr_arbiter #(
    parameter int REQS  = 3,
    parameter int PTR_W = $clog2(REQS)
) (
    input  logic [REQS-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [REQS-1:0]  o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);
    logic [PTR_W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        if (i_en) begin
            for (int k = 0; k < REQS; k++) begin
                w_cand = PTR_W'((int'(i_ptr) + k) % REQS);
                if (!o_any && i_req[w_cand]) begin
                    o_grant[w_cand] = 1'b1;
                    o_idx           = w_cand;
                    o_any           = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter driving the register file write port (we3/wa3/wd3).
// Optional per-requester grant and r0-drop counters are built only with RF_WB_STATS_EN.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int N    = 32,
    parameter int REQS = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic [REQS-1:0]                    req_valid,
    input  logic [REQS-1:0][REG_ADDR_W-1:0]    req_addr,
    input  logic [REQS-1:0][N-1:0]             req_data,
    output logic [REQS-1:0]                    req_ready,
    output logic                               we3,
    output logic [REG_ADDR_W-1:0]              wa3,
    output logic [N-1:0]                       wd3,
    output logic [REQS-1:0][STAT_W-1:0]        stat_grants,
    output logic [STAT_W-1:0]                  stat_drops
);
    localparam int PTR_W = $clog2(REQS);

    logic [PTR_W-1:0] r_ptr;
    logic             r_we3;
    reg_addr_t        r_wa3;
    logic [N-1:0]     r_wd3;

    logic [REQS-1:0]  w_grant;
    logic [PTR_W-1:0] w_idx;
    logic             w_any;
    reg_addr_t        w_addr;
    logic             w_real;

    // Gating with reset keeps requests presented during reset unconsumed.
    rr_arbiter #(.REQS(REQS), .PTR_W(PTR_W)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (!stall && !reset),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign req_ready = w_grant;
    assign w_addr    = req_addr[w_idx];
    assign w_real    = w_any && (w_addr != REG_ZERO);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            r_we3 <= 1'b0;
            r_wa3 <= '0;
            r_wd3 <= '0;
        end else begin
            if (w_any)
                r_ptr <= (w_idx == PTR_W'(REQS-1)) ? '0 : w_idx + 1'b1;
            r_we3 <= w_real;
            // r0 writes are consumed but leave wa3/wd3 untouched.
            if (w_real) begin
                r_wa3 <= w_addr;
                r_wd3 <= req_data[w_idx];
            end
        end
    end

    assign we3 = r_we3;
    assign wa3 = r_wa3;
    assign wd3 = r_wd3;

`ifdef RF_WB_STATS_EN
    stat_t [REQS-1:0] r_grants;
    stat_t            r_drops;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grants <= '0;
            r_drops  <= '0;
        end else if (w_any) begin
            if (r_grants[w_idx] != '1)
                r_grants[w_idx] <= r_grants[w_idx] + 1'b1;
            if (w_addr == REG_ZERO && r_drops != '1)
                r_drops <= r_drops + 1'b1;
        end
    end

    assign stat_grants = r_grants;
    assign stat_drops  = r_drops;
`else
    assign stat_grants = '0;
    assign stat_drops  = '0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_rf_wb_arbiter;
    localparam int N    = 32;
    localparam int REQS = 3;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       stall;
    logic [REQS-1:0]            req_valid;
    logic [REQS-1:0][4:0]       req_addr;
    logic [REQS-1:0][N-1:0]     req_data;
    logic [REQS-1:0]            req_ready;
    logic                       we3;
    logic [4:0]                 wa3;
    logic [N-1:0]               wd3;
    logic [REQS-1:0][15:0]      stat_grants;
    logic [15:0]                stat_drops;

    rf_wb_arbiter #(.N(N), .REQS(REQS)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .we3(we3), .wa3(wa3), .wd3(wd3),
        .stat_grants(stat_grants), .stat_drops(stat_drops)
    );

    always #5 clk = ~clk;

    // Register file fed by the DUT port, written on the falling edge.
    logic [N-1:0] tb_rf [32];
    always @(negedge clk) if (we3 && wa3 != 5'd0) tb_rf[wa3] <= wd3;

`ifdef RF_WB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Behavioural model
    int           m_ptr;
    logic         m_we;
    logic [4:0]   m_wa;
    logic [N-1:0] m_wd;
    int           m_grants [REQS];
    int           m_drops;
    logic [N-1:0] m_rf [32];

    int checks = 0;
    int errors = 0;

    function automatic int pick();
        if (reset || stall) return -1;
        for (int k = 0; k < REQS; k++)
            if (req_valid[(m_ptr + k) % REQS]) return (m_ptr + k) % REQS;
        return -1;
    endfunction

    function automatic logic [REQS-1:0] pick_mask();
        int g;
        g = pick();
        return (g < 0) ? '0 : (REQS'(1) << g);
    endfunction

    function automatic logic [15:0] exp_grants(int i);
        return STATS ? 16'(m_grants[i]) : 16'd0;
    endfunction

    function automatic logic [15:0] exp_drops();
        return STATS ? 16'(m_drops) : 16'd0;
    endfunction

    // Advance one clock: model follows the spec rules, the granted producer drops its request.
    task automatic tick();
        int g;
        g = pick();
        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_we = 0; m_wa = 0; m_wd = 0; m_drops = 0;
            for (int i = 0; i < REQS; i++) m_grants[i] = 0;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % REQS;
            if (m_grants[g] < 16'hFFFF) m_grants[g]++;
            if (req_addr[g] == 5'd0) begin
                m_we = 0;
                if (m_drops < 16'hFFFF) m_drops++;
            end else begin
                m_we = 1; m_wa = req_addr[g]; m_wd = req_data[g];
                m_rf[req_addr[g]] = req_data[g];
            end
        end else begin
            m_we = 0;
        end
        #1;
        if (g >= 0) req_valid[g] = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; req_valid = '1;
        req_addr = {5'd3, 5'd2, 5'd1}; req_data = {32'd3, 32'd2, 32'd1};
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
        tick(); tick();
        checks++; if (we3 !== 1'b0 || wa3 !== 5'd0 || wd3 !== '0) begin
            errors++; $display("FAIL reset_port got we=%b wa=%0d wd=%h want 0/0/0", we3, wa3, wd3); end
        checks++; if (stat_drops !== 16'd0 || stat_grants !== '0) begin
            errors++; $display("FAIL reset_stats got drops=%0d grants=%h want 0", stat_drops, stat_grants); end
        req_valid = '0; reset = 0; #1;
    endtask

    task automatic test_single();
        req_valid[1] = 1; req_addr[1] = 5'd5; req_data[1] = 32'h1234; #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got %b want 010", req_ready); end
        tick();
        checks++; if (we3 !== 1'b1 || wa3 !== 5'd5 || wd3 !== 32'h1234) begin
            errors++; $display("FAIL single_write got we=%b wa=%0d wd=%h want 1/5/1234", we3, wa3, wd3); end
        tick();
        checks++; if (we3 !== 1'b0 || wa3 !== 5'd5 || wd3 !== 32'h1234) begin
            errors++; $display("FAIL single_after got we=%b wa=%0d wd=%h want 0/5/1234", we3, wa3, wd3); end
    endtask

    task automatic test_all_valid();
        int exp_order [6] = '{0, 1, 2, 0, 1, 2};
        reset = 1; tick(); reset = 0;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < REQS; i++) begin
                req_valid[i] = 1; req_addr[i] = 5'(i + 10); req_data[i] = $urandom;
            end
            #1;
            checks++; if (req_ready !== (REQS'(1) << exp_order[c])) begin
                errors++; $display("FAIL rr_order cyc %0d got %b want idx %0d", c, req_ready, exp_order[c]); end
            tick();
            checks++; if (we3 !== 1'b1 || wa3 !== 5'(exp_order[c] + 10)) begin
                errors++; $display("FAIL rr_write cyc %0d got we=%b wa=%0d want 1/%0d", c, we3, wa3, exp_order[c] + 10); end
        end
        req_valid = '0; #1;
    endtask

    task automatic test_same_reg();
        req_valid[1] = 1; req_addr[1] = 5'd3; req_data[1] = 32'h33; tick(); // leaves ptr at 2
        req_valid[0] = 1; req_addr[0] = 5'd7; req_data[0] = 32'hA;
        req_valid[2] = 1; req_addr[2] = 5'd7; req_data[2] = 32'hB; #1;
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL same_first got %b want 100", req_ready); end
        tick();
        checks++; if (wd3 !== 32'hB || req_ready !== 3'b001) begin
            errors++; $display("FAIL same_second got wd=%h ready=%b want B/001", wd3, req_ready); end
        tick();
        checks++; if (we3 !== 1'b1 || wa3 !== 5'd7 || wd3 !== 32'hA) begin
            errors++; $display("FAIL same_last got we=%b wa=%0d wd=%h want 1/7/A", we3, wa3, wd3); end
        @(negedge clk); #1;
        checks++; if (tb_rf[7] !== 32'hA) begin errors++; $display("FAIL same_rf got %h want A", tb_rf[7]); end
    endtask

    task automatic test_r0();
        req_valid[0] = 1; req_addr[0] = 5'd0; req_data[0] = $urandom; #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL r0_ready got %b want 001", req_ready); end
        tick();
        checks++; if (we3 !== 1'b0 || wa3 !== 5'd7 || req_valid[0] !== 1'b0) begin
            errors++; $display("FAIL r0_write got we=%b wa=%0d want 0/7", we3, wa3); end
        checks++; if (stat_drops !== (STATS ? 16'd1 : 16'd0)) begin
            errors++; $display("FAIL r0_drops got %0d want %0d", stat_drops, STATS ? 1 : 0); end
    endtask

    task automatic test_stall();
        stall = 1;
        req_valid[1] = 1; req_addr[1] = 5'd9;  req_data[1] = 32'h99;
        req_valid[2] = 1; req_addr[2] = 5'd10; req_data[2] = 32'hAA;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL stall_ready cyc %0d got %b want 0", c, req_ready); end
            tick();
            checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL stall_we cyc %0d got %b want 0", c, we3); end
        end
        stall = 0; #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL stall_release got %b want 010", req_ready); end
        tick();
        checks++; if (we3 !== 1'b1 || wa3 !== 5'd9) begin
            errors++; $display("FAIL stall_write got we=%b wa=%0d want 1/9", we3, wa3); end
    endtask

    task automatic test_reset_mid();
        #1; tick(); // requester 2 still pending: granted here
        checks++; if (we3 !== 1'b1 || wa3 !== 5'd10) begin
            errors++; $display("FAIL mid_grant got we=%b wa=%0d want 1/10", we3, wa3); end
        reset = 1;
        req_valid[1] = 1; req_addr[1] = 5'd4; req_data[1] = 32'h44; #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL mid_ready got %b want 0", req_ready); end
        tick();
        checks++; if (we3 !== 1'b0 || stat_drops !== 16'd0 || stat_grants !== '0) begin
            errors++; $display("FAIL mid_reset got we=%b drops=%0d grants=%h want 0", we3, stat_drops, stat_grants); end
        reset = 0;
        req_valid[2] = 1; req_addr[2] = 5'd6; req_data[2] = 32'h66; #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL mid_ptr got %b want 010", req_ready); end
        tick(); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < REQS; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    req_valid[i] = 1;
                    req_addr[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    req_data[i]  = $urandom;
                end
            end
            stall = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 63) == 0);
            #1;
            checks++; if (req_ready !== pick_mask()) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, req_ready, pick_mask()); end
            tick();
            checks++; if (we3 !== m_we || (m_we && (wa3 !== m_wa || wd3 !== m_wd))) begin
                errors++; $display("FAIL rnd_port cyc %0d got %b/%0d/%h want %b/%0d/%h", c, we3, wa3, wd3, m_we, m_wa, m_wd); end
            checks++; if (stat_drops !== exp_drops()) begin
                errors++; $display("FAIL rnd_drops cyc %0d got %0d want %0d", c, stat_drops, exp_drops()); end
            for (int i = 0; i < REQS; i++) begin
                checks++; if (stat_grants[i] !== exp_grants(i)) begin
                    errors++; $display("FAIL rnd_grants[%0d] cyc %0d got %0d want %0d", i, c, stat_grants[i], exp_grants(i)); end
            end
        end
        stall = 0; reset = 0; req_valid = '0;
        tick(); @(negedge clk); #1;
        for (int r = 1; r < 32; r++) begin
            checks++; if (tb_rf[r] !== m_rf[r]) begin
                errors++; $display("FAIL rnd_rf r%0d got %h want %h", r, tb_rf[r], m_rf[r]); end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin tb_rf[r] = '0; m_rf[r] = '0; end
        m_ptr = 0; m_we = 0; m_wa = 0; m_wd = 0; m_drops = 0;
        for (int i = 0; i < REQS; i++) m_grants[i] = 0;
        reset = 1; stall = 0; req_valid = '0; req_addr = '0; req_data = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_all_valid();
        test_same_reg();
        test_r0();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
